muldiv_ctrl: RTL and testbench

//  Sequencer for the EX-stage multi-cycle units: the pipelined multiplier (mul) and the

---
 rtl/muldiv_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_muldiv_ctrl.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_ctrl.sv
// HI/LO sequencer for the EX stage: launches multiply/divide operations, stalls the pipe
// until the result arrives, and owns the architectural HI and LO registers.
module muldiv_ctrl #(
  parameter int unsigned MUL_LAT = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        op_valid,
  input  logic [2:0]  op_code,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        flush,
  output logic        stallreq,
  output logic        mul_signed,
  output logic [31:0] mul_ina,
  output logic [31:0] mul_inb,
  input  logic [63:0] mul_result,
  output logic        div_start,
  output logic        div_signed,
  output logic [31:0] div_opdata1,
  output logic [31:0] div_opdata2,
  output logic        div_annul,
  input  logic [63:0] div_result,
  input  logic        div_ready,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  localparam int unsigned CNT_W = $clog2(MUL_LAT + 1);

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL_WAIT,
    S_DIV_WAIT,
    S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        a_q, b_q;
  logic               sign_q;
  logic [31:0]        hi_q, lo_q;

  logic               latch_ops;
  logic               latch_signed;
  logic               stall_c;
  logic               start_c;
  logic               annul_c;
  logic               hi_we, lo_we;
  logic               hilo_we;
  logic [63:0]        hilo_d;

  // NOTE: every signal driven here gets a default first, so no path can leave it
  // unassigned and infer a latch.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    latch_ops    = 1'b0;
    latch_signed = 1'b0;
    stall_c      = 1'b0;
    start_c      = 1'b0;
    annul_c      = 1'b0;
    hi_we        = 1'b0;
    lo_we        = 1'b0;
    hilo_we      = 1'b0;
    hilo_d       = 64'd0;

    unique case (state_q)
      S_IDLE: begin
        if (op_valid && !flush) begin
          unique case (op_code)
            OP_MULT, OP_MULTU: begin
              latch_ops    = 1'b1;
              latch_signed = (op_code == OP_MULT);
              cnt_d        = CNT_W'(MUL_LAT);
              stall_c      = 1'b1;
              state_d      = S_MUL_WAIT;
            end
            OP_DIV, OP_DIVU: begin
              latch_ops    = 1'b1;
              latch_signed = (op_code == OP_DIV);
              stall_c      = 1'b1;
              // A zero divisor never reaches the divider; the instruction just retires.
              state_d      = (src_b != 32'd0) ? S_DIV_WAIT : S_DONE;
            end
            OP_MTHI: hi_we = 1'b1;
            OP_MTLO: lo_we = 1'b1;
            default: ;
          endcase
        end
      end

      S_MUL_WAIT: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          stall_c = 1'b1;
          if (cnt_q == '0) begin
            hilo_we = 1'b1;
            hilo_d  = mul_result;
            state_d = S_DONE;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end

      S_DIV_WAIT: begin
        if (flush) begin
          annul_c = 1'b1;
          state_d = S_IDLE;
        end else begin
          start_c = 1'b1;
          stall_c = 1'b1;
          if (div_ready) begin
            hilo_we = 1'b1;
            hilo_d  = div_result;
            state_d = S_DONE;
          end
        end
      end

      S_DONE: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the pre-edge value of every other register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      sign_q  <= 1'b0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (latch_ops) begin
        a_q    <= src_a;
        b_q    <= src_b;
        sign_q <= latch_signed;
      end
      // Unit completion and MTHI/MTLO are in different states, so they never collide.
      if (hilo_we) begin
        hi_q <= hilo_d[63:32];
        lo_q <= hilo_d[31:0];
      end else begin
        if (hi_we) hi_q <= src_a;
        if (lo_we) lo_q <= src_a;
      end
    end
  end

  // The accept-cycle stall is combinational from op_valid, so it is masked while
  // reset is asserted to keep the stall controller quiet.
  assign stallreq    = stall_c & resetn;
  assign div_start   = start_c;
  assign div_annul   = annul_c;

  assign mul_signed  = sign_q;
  assign mul_ina     = a_q;
  assign mul_inb     = b_q;
  assign div_signed  = sign_q;
  assign div_opdata1 = a_q;
  assign div_opdata2 = b_q;

  assign hi_o        = hi_q;
  assign lo_o        = lo_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Randomised and directed bench for muldiv_ctrl with behavioural mul/div units and an
// instruction-level reference model of HI/LO and stall length.
module tb_muldiv_ctrl;

  localparam int unsigned MUL_LAT = 2;

  logic        clk = 1'b0;
  logic        resetn;
  logic        op_valid;
  logic [2:0]  op_code;
  logic [31:0] src_a, src_b;
  logic        flush;
  logic        stallreq;
  logic        mul_signed;
  logic [31:0] mul_ina, mul_inb;
  logic [63:0] mul_result;
  logic        div_start, div_signed, div_annul;
  logic [31:0] div_opdata1, div_opdata2;
  logic [63:0] div_result;
  logic        div_ready;
  logic [31:0] hi_o, lo_o;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;
  int          div_lat = 33;

  always #5 clk = ~clk;

  muldiv_ctrl #(.MUL_LAT(MUL_LAT)) dut (
    .clk(clk), .resetn(resetn), .op_valid(op_valid), .op_code(op_code),
    .src_a(src_a), .src_b(src_b), .flush(flush), .stallreq(stallreq),
    .mul_signed(mul_signed), .mul_ina(mul_ina), .mul_inb(mul_inb), .mul_result(mul_result),
    .div_start(div_start), .div_signed(div_signed), .div_opdata1(div_opdata1),
    .div_opdata2(div_opdata2), .div_annul(div_annul), .div_result(div_result),
    .div_ready(div_ready), .hi_o(hi_o), .lo_o(lo_o)
  );

  function automatic logic [63:0] mul_ref(logic [31:0] a, logic [31:0] b, logic s);
    longint sa, sb, p;
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      p  = sa * sb;
      return 64'(p);
    end
    return {32'd0, a} * {32'd0, b};
  endfunction

  function automatic logic [63:0] div_ref(logic [31:0] a, logic [31:0] b, logic s);
    longint sa, sb, q, r;
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = sa / sb;
      r  = sa % sb;
      return {r[31:0], q[31:0]};
    end
    return {a % b, a / b};
  endfunction

  // Pipelined multiplier: result appears MUL_LAT cycles after operands are presented.
  logic [63:0] mul_pipe [MUL_LAT] = '{default: 64'd0};
  always @(posedge clk) begin
    mul_pipe[0] <= mul_ref(mul_ina, mul_inb, mul_signed);
    for (int i = 1; i < int'(MUL_LAT); i++) mul_pipe[i] <= mul_pipe[i-1];
  end
  assign mul_result = mul_pipe[MUL_LAT-1];

  // Start/ready divider: ready rises div_lat cycles after start and holds until start drops.
  int div_cnt = 0;
  initial begin
    div_ready  = 1'b0;
    div_result = 64'd0;
  end
  always @(posedge clk) begin
    if (!resetn || div_annul || !div_start) begin
      div_cnt   <= 0;
      div_ready <= 1'b0;
    end else if (!div_ready) begin
      if (div_cnt == div_lat - 1) begin
        div_ready  <= 1'b1;
        div_result <= div_ref(div_opdata1, div_opdata2, div_signed);
      end
      div_cnt <= div_cnt + 1;
    end
  end

  // Instruction-level reference: architectural HI/LO effect and cycles EX is held.
  task automatic model_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int exp_stall, output int exp_starts);
    logic [63:0] r;
    exp_stall  = 0;
    exp_starts = 0;
    case (op)
      3'd0, 3'd1: begin
        r = mul_ref(a, b, op == 3'd0);
        {m_hi, m_lo} = r;
        exp_stall = MUL_LAT + 2;
      end
      3'd2, 3'd3: begin
        if (b == 32'd0) exp_stall = 1;
        else begin
          r = div_ref(a, b, op == 3'd2);
          {m_hi, m_lo} = r;
          exp_stall  = div_lat + 2;
          exp_starts = div_lat + 1;
        end
      end
      3'd4: m_hi = a;
      3'd5: m_lo = a;
      default: ;
    endcase
  endtask

  // Holds the instruction in EX until stallreq releases it; counts stalled and start cycles.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int stalls, output int starts);
    int guard;
    stalls = 0;
    starts = 0;
    guard  = 0;
    @(negedge clk);
    op_valid = 1'b1;
    op_code  = op;
    src_a    = a;
    src_b    = b;
    #1;
    while (stallreq === 1'b1 && guard < 5000) begin
      stalls++;
      if (div_start === 1'b1) starts++;
      @(negedge clk);
      #1;
      guard++;
    end
    if (div_start === 1'b1) starts++;
    checks++;
    if (guard >= 5000) begin
      errors++;
      $display("FAIL run_op_timeout: op %0d still stalled after %0d cycles, required release", op, guard);
    end
    @(posedge clk);
    #1;
    op_valid = 1'b0;
  endtask

  task automatic test_reset();
    resetn   = 1'b0;
    flush    = 1'b0;
    op_valid = 1'b1;
    op_code  = 3'd0;
    src_a    = 32'h1234;
    src_b    = 32'h5678;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if ({stallreq, div_start, div_annul, mul_signed, div_signed} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b required 00000",
               {stallreq, div_start, div_annul, mul_signed, div_signed});
    end
    checks++;
    if ({hi_o, lo_o, mul_ina, mul_inb, div_opdata1, div_opdata2} !== 192'd0) begin
      errors++;
      $display("FAIL reset_data: hi %h lo %h ina %h inb %h required all 0", hi_o, lo_o, mul_ina, mul_inb);
    end
    op_valid = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic test_mult();
    int st, sn, est, esn;
    model_op(3'd0, 32'hFFFF_FFFD, 32'd7, est, esn);
    run_op(3'd0, 32'hFFFF_FFFD, 32'd7, st, sn);
    checks++;
    if (st !== 4) begin errors++; $display("FAIL mult_stall: got %0d required 4", st); end
    checks++;
    if (hi_o !== 32'hFFFF_FFFF || lo_o !== 32'hFFFF_FFEB) begin
      errors++;
      $display("FAIL mult_hilo: got %h_%h required ffffffff_ffffffeb", hi_o, lo_o);
    end
    #1;
    checks++;
    if (stallreq !== 1'b0) begin errors++; $display("FAIL mult_after: stallreq %b required 0", stallreq); end
  endtask

  task automatic test_divu();
    int st, sn, est, esn;
    div_lat = 33;
    model_op(3'd3, 32'd100, 32'd7, est, esn);
    run_op(3'd3, 32'd100, 32'd7, st, sn);
    checks++;
    if (st !== 35) begin errors++; $display("FAIL divu_stall: got %0d required 35", st); end
    checks++;
    if (sn !== 34) begin errors++; $display("FAIL divu_start: got %0d required 34", sn); end
    checks++;
    if (hi_o !== 32'd2 || lo_o !== 32'd14) begin
      errors++;
      $display("FAIL divu_hilo: got %h_%h required 00000002_0000000e", hi_o, lo_o);
    end
  endtask

  task automatic test_div_zero();
    int st, sn, est, esn;
    model_op(3'd4, 32'h1234_5678, 32'd0, est, esn);
    run_op(3'd4, 32'h1234_5678, 32'd0, st, sn);
    model_op(3'd5, 32'h9ABC_DEF0, 32'd0, est, esn);
    run_op(3'd5, 32'h9ABC_DEF0, 32'd0, st, sn);
    model_op(3'd2, 32'd55, 32'd0, est, esn);
    run_op(3'd2, 32'd55, 32'd0, st, sn);
    checks++;
    if (st !== 1 || sn !== 0) begin
      errors++;
      $display("FAIL divzero_stall: stall %0d start %0d required 1 and 0", st, sn);
    end
    checks++;
    if (hi_o !== 32'h1234_5678 || lo_o !== 32'h9ABC_DEF0) begin
      errors++;
      $display("FAIL divzero_hilo: got %h_%h required 12345678_9abcdef0", hi_o, lo_o);
    end
  endtask

  task automatic test_back_to_back();
    int st1, st2, sn, est, esn;
    model_op(3'd4, 32'hDEAD_BEEF, 32'd0, est, esn);
    run_op(3'd4, 32'hDEAD_BEEF, 32'd0, st1, sn);
    model_op(3'd5, 32'h1, 32'd0, est, esn);
    run_op(3'd5, 32'h1, 32'd0, st2, sn);
    checks++;
    if (st1 !== 0 || st2 !== 0) begin
      errors++;
      $display("FAIL mt_stall: got %0d/%0d required 0/0", st1, st2);
    end
    checks++;
    if (hi_o !== 32'hDEAD_BEEF || lo_o !== 32'h1) begin
      errors++;
      $display("FAIL mt_hilo: got %h_%h required deadbeef_00000001", hi_o, lo_o);
    end
  endtask

  task automatic test_flush_div();
    int st, sn, est, esn;
    logic [31:0] a, b;
    div_lat = 33;
    @(negedge clk);
    op_valid = 1'b1;
    op_code  = 3'd2;
    src_a    = 32'd1000;
    src_b    = 32'd3;
    repeat (4) @(negedge clk);
    #1;
    checks++;
    if (div_start !== 1'b1 || stallreq !== 1'b1) begin
      errors++;
      $display("FAIL flush_pre: start %b stall %b required 1 1", div_start, stallreq);
    end
    @(negedge clk);
    flush = 1'b1;
    #1;
    checks++;
    if ({div_annul, div_start, stallreq} !== 3'b100) begin
      errors++;
      $display("FAIL flush_cycle: annul/start/stall %b required 100", {div_annul, div_start, stallreq});
    end
    @(negedge clk);
    flush    = 1'b0;
    op_valid = 1'b0;
    #1;
    checks++;
    if ({div_annul, div_start, stallreq} !== 3'b000) begin
      errors++;
      $display("FAIL flush_after: annul/start/stall %b required 000", {div_annul, div_start, stallreq});
    end
    repeat (40) @(negedge clk);
    #1;
    checks++;
    if (hi_o !== m_hi || lo_o !== m_lo) begin
      errors++;
      $display("FAIL flush_hilo: got %h_%h required %h_%h", hi_o, lo_o, m_hi, m_lo);
    end
    a = $urandom;
    b = $urandom;
    model_op(3'd1, a, b, est, esn);
    run_op(3'd1, a, b, st, sn);
    checks++;
    if (st !== est || hi_o !== m_hi || lo_o !== m_lo) begin
      errors++;
      $display("FAIL flush_next_mult: stall %0d hilo %h_%h required %0d %h_%h", st, hi_o, lo_o, est, m_hi, m_lo);
    end
  endtask

  task automatic test_reset_mid_mul();
    @(negedge clk);
    op_valid = 1'b1;
    op_code  = 3'd0;
    src_a    = 32'd9;
    src_b    = 32'd11;
    repeat (2) @(negedge clk);
    #2;
    resetn = 1'b0;
    #1;
    checks++;
    if ({stallreq, div_start, div_annul, mul_signed} !== 4'b0 ||
        {hi_o, lo_o, mul_ina, mul_inb} !== 128'd0) begin
      errors++;
      $display("FAIL reset_mid: stall %b hi %h lo %h ina %h inb %h required all 0",
               stallreq, hi_o, lo_o, mul_ina, mul_inb);
    end
    op_valid = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    m_hi = 32'd0;
    m_lo = 32'd0;
    repeat (MUL_LAT + 3) @(negedge clk);
    #1;
    checks++;
    if (hi_o !== 32'd0 || lo_o !== 32'd0 || stallreq !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: hi %h lo %h stall %b required 0 0 0", hi_o, lo_o, stallreq);
    end
  endtask

  task automatic test_random();
    int st, sn, est, esn;
    logic [2:0]  op;
    logic [31:0] a, b;
    for (int n = 0; n < 60; n++) begin
      op      = 3'($urandom_range(0, 7));
      a       = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : 32'($urandom);
      b       = ($urandom_range(0, 5) == 0) ? 32'd0 : 32'($urandom);
      div_lat = int'($urandom_range(1, 12));
      model_op(op, a, b, est, esn);
      run_op(op, a, b, st, sn);
      checks++;
      if (st !== est || sn !== esn) begin
        errors++;
        $display("FAIL rand_timing[%0d]: op %0d stall %0d start %0d required %0d %0d", n, op, st, sn, est, esn);
      end
      checks++;
      if (hi_o !== m_hi || lo_o !== m_lo) begin
        errors++;
        $display("FAIL rand_hilo[%0d]: op %0d a %h b %h got %h_%h required %h_%h",
                 n, op, a, b, hi_o, lo_o, m_hi, m_lo);
      end
      if ($urandom_range(0, 2) == 0) begin
        @(negedge clk);
        op_code = 3'($urandom_range(0, 7));
      end
    end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_divu();
    test_div_zero();
    test_back_to_back();
    test_flush_div();
    test_reset_mid_mul();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
